junction_cycle_controller: RTL

Sequences one network junction's FF, BP and UP processor sets over the `cpc = p*fo/z` clock cycles each training sample occupies. Generates the shared cycle index, per-set valid strobes, the delayed activation write strobe/address (covering activation-LUT latency) and the effective `etapos` fed to the UP set. FF of sample k overlaps BP/UP of sample k-1. It sits between the top-level sample feed and the processor sets and memories of one junction.

---
 rtl/junction_cycle_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/junction_cycle_controller.sv
// junction_cycle_controller: sequences FF/BP/UP processor sets of one junction over cpc cycles per sample
// FF of sample k overlaps BP/UP of sample k-1; activation writes trail ff_valid by FF_LAT cycles.
module junction_cycle_controller #(
    parameter int P = 16,
    parameter int N = 8,
    parameter int Z = 8,
    parameter int FI = 4,
    parameter int FO = 2,
    parameter int FRAC_BITS = 10,
    parameter int FF_LAT = 1,
    localparam int CPC = P * FO / Z,
    localparam int CW = (CPC > 1) ? $clog2(CPC) : 1,
    localparam int EW = $clog2(FRAC_BITS + 2)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          sample_valid_i,
    output logic          sample_ready_o,
    input  logic [EW-1:0] eta_cfg_i,
    input  logic          eta_cfg_we_i,
    output logic [CW-1:0] cycle_index_o,
    output logic          ff_valid_o,
    output logic          bp_valid_o,
    output logic          up_valid_o,
    output logic [EW-1:0] etapos_o,
    output logic          act_we_o,
    output logic [CW-1:0] act_addr_o,
    output logic          sample_done_o,
    output logic          busy_o
);
    if (P * FO != N * FI) begin : g_bad_geometry
        $error("junction_cycle_controller: p*fo must equal n*fi");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CW-1:0] LAST = CW'(CPC - 1);
    localparam logic [EW-1:0] ETA_MAX = EW'(FRAC_BITS + 1);

    state_t                   state_q;
    logic   [CW-1:0]          ci_q, ci_d;
    logic                     have_prev_q;
    logic   [EW-1:0]          eta_q, eta_d;
    logic   [FF_LAT-1:0]      dly_v_q;
    logic   [FF_LAT-1:0][CW-1:0] dly_a_q;
    logic                     last;

    assign last = ci_q == LAST;
    assign ci_d = last ? '0 : ci_q + CW'(1);
    assign eta_d = (eta_cfg_i > ETA_MAX) ? ETA_MAX : eta_cfg_i;

    assign cycle_index_o = ci_q;
    assign ff_valid_o = state_q == RUN;
    assign up_valid_o = (state_q == DRAIN) || (state_q == RUN && have_prev_q);
    assign bp_valid_o = up_valid_o;
    assign sample_ready_o = (state_q == IDLE) || (state_q == RUN && last);
    assign etapos_o = up_valid_o ? eta_q : '0;
    assign sample_done_o = up_valid_o && last;
    assign act_we_o = dly_v_q[FF_LAT-1];
    assign act_addr_o = dly_a_q[FF_LAT-1];
    assign busy_o = (state_q != IDLE) || (|dly_v_q);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            ci_q <= '0;
            have_prev_q <= 1'b0;
            eta_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ci_q <= '0;
                    if (sample_valid_i) state_q <= RUN;
                    if (eta_cfg_we_i) eta_q <= eta_d;
                end
                RUN: begin
                    ci_q <= ci_d;
                    if (last) begin
                        have_prev_q <= 1'b1;
                        if (!sample_valid_i) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    ci_q <= ci_d;
                    if (last) begin
                        state_q <= IDLE;
                        have_prev_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The delay line models activation-LUT latency, so it shifts in every state.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            dly_v_q <= '0;
            dly_a_q <= '0;
        end else begin
            dly_v_q[0] <= ff_valid_o;
            dly_a_q[0] <= ci_q;
            for (int i = 1; i < FF_LAT; i++) begin
                dly_v_q[i] <= dly_v_q[i-1];
                dly_a_q[i] <= dly_a_q[i-1];
            end
        end
    end
endmodule
